// File: rtl/glitch_sequencer_pkg.sv
// glitch_sequencer_pkg: shared state encoding, glitch mode bit positions and default widths
package glitch_sequencer_pkg;
  localparam int CNT_W_DEF  = 16;
  localparam int REP_W_DEF  = 8;
  localparam int MODE_W_DEF = 8;
  localparam int MODE_ZERO  = 0;
  localparam int MODE_ONE   = 1;
  localparam int MODE_INV   = 2;
  localparam int MODE_GLA   = 3;
  localparam int MODE_GLB   = 4;
  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_DELAY, S_GLITCH, S_GAP, S_DONE
  } state_t;
endpackage

// File: rtl/glitch_trig_sync.sv
// glitch_trig_sync: 2-flop trigger synchronizer with registered rising-edge detector
module glitch_trig_sync (
  input  logic clk_in,
  input  logic rst_n,
  input  logic i_trigger,
  input  logic i_clr,
  output logic o_trig_det
);
  logic r_s1, r_s2, r_s3, r_det;
  // i_clr presets the history high so edges already in flight (or a held-high pin) never fire
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_s3  <= 1'b0;
      r_det <= 1'b0;
    end else begin
      r_s1  <= i_trigger;
      r_s2  <= i_clr ? 1'b1 : r_s1;
      r_s3  <= i_clr ? 1'b1 : r_s2;
      r_det <= !i_clr && r_s2 && !r_s3;
    end
  end
  assign o_trig_det = r_det;
endmodule

// File: rtl/glitch_sequencer.sv
// glitch_sequencer: armed/triggered sequencer producing timed glitch_en pulses and mode word
module glitch_sequencer
  import glitch_sequencer_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int REP_W  = REP_W_DEF,
  parameter int MODE_W = MODE_W_DEF
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              arm,
  input  logic              abort,
  input  logic              trigger,
  input  logic [CNT_W-1:0]  cfg_delay,
  input  logic [CNT_W-1:0]  cfg_width,
  input  logic [CNT_W-1:0]  cfg_gap,
  input  logic [REP_W-1:0]  cfg_repeat,
  input  logic [MODE_W-1:0] cfg_mode,
  output logic              glitch_en,
  output logic [MODE_W-1:0] glitch_mode,
  output logic              armed,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  output logic [REP_W-1:0]  pulse_cnt
);
  state_t r_state, w_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, r_delay, r_width, r_gap;
  logic [REP_W-1:0] r_repeat, r_pulse;
  logic [MODE_W-1:0] r_mode, r_gmode, w_gmode_nxt;
  logic r_en, r_armed, r_busy, r_done, r_err;
  logic w_en_nxt, w_armed_nxt, w_busy_nxt, w_done_nxt;
  logic w_trig, w_arm_ok, w_arm_bad, w_cnt_z, w_last;

  assign w_arm_ok  = arm && !abort && r_state == S_IDLE && cfg_mode != '0;
  assign w_arm_bad = arm && !abort && r_state == S_IDLE && cfg_mode == '0;
  assign w_cnt_z   = r_cnt == '0;
  assign w_last    = r_pulse + REP_W'(1) == r_repeat;

  glitch_trig_sync u_sync (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .i_trigger  (trigger),
    .i_clr      (w_arm_ok),
    .o_trig_det (w_trig)
  );

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    case (r_state)
      S_IDLE:   w_next = w_arm_ok ? S_ARMED : S_IDLE;
      S_ARMED: if (w_trig) begin
        w_next    = r_delay == '0 ? S_GLITCH : S_DELAY;
        w_cnt_nxt = r_delay == '0 ? r_width : r_delay - CNT_W'(1);
      end
      S_DELAY: begin
        w_next    = w_cnt_z ? S_GLITCH : S_DELAY;
        w_cnt_nxt = w_cnt_z ? r_width : r_cnt - CNT_W'(1);
      end
      S_GLITCH: begin
        w_next    = !w_cnt_z ? S_GLITCH : w_last ? S_DONE : S_GAP;
        w_cnt_nxt = w_cnt_z ? r_gap : r_cnt - CNT_W'(1);
      end
      S_GAP: begin
        w_next    = w_cnt_z ? S_GLITCH : S_GAP;
        w_cnt_nxt = w_cnt_z ? r_width : r_cnt - CNT_W'(1);
      end
      default:  w_next = S_IDLE;
    endcase
    if (abort) w_next = S_IDLE;
  end

  // outputs are registered from the next state so they line up with the state they describe
  always_comb begin
    w_en_nxt    = w_next == S_GLITCH;
    w_gmode_nxt = w_en_nxt ? r_mode : '0;
    w_armed_nxt = w_next == S_ARMED;
    w_busy_nxt  = w_next == S_DELAY || w_next == S_GLITCH || w_next == S_GAP;
    w_done_nxt  = w_next == S_DONE;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_en    <= 1'b0;
      r_gmode <= '0;
      r_armed <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_en    <= w_en_nxt;
      r_gmode <= w_gmode_nxt;
      r_armed <= w_armed_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_arm_bad;
    end
  end

  // shadow config holds post-substitution reload values so counters never wrap
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_delay  <= '0;
      r_width  <= '0;
      r_gap    <= '0;
      r_repeat <= '0;
      r_mode   <= '0;
    end else if (w_arm_ok) begin
      r_delay  <= cfg_delay;
      r_width  <= cfg_width == '0 ? '0 : cfg_width - CNT_W'(1);
      r_gap    <= cfg_gap == '0 ? '0 : cfg_gap - CNT_W'(1);
      r_repeat <= cfg_repeat == '0 ? REP_W'(1) : cfg_repeat;
      r_mode   <= cfg_mode;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) r_pulse <= '0;
    else if (w_arm_ok) r_pulse <= '0;
    else if (r_state == S_GLITCH && w_cnt_z && !abort) r_pulse <= r_pulse + REP_W'(1);
  end

  assign glitch_en   = r_en;
  assign glitch_mode = r_gmode;
  assign armed       = r_armed;
  assign busy        = r_busy;
  assign done        = r_done;
  assign cfg_err     = r_err;
  assign pulse_cnt   = r_pulse;
endmodule

// File: tb/tb_glitch_sequencer.sv
// tb_glitch_sequencer: scoreboard bench comparing per-cycle glitch outputs against a timing model
module tb_glitch_sequencer;
  import glitch_sequencer_pkg::*;
  logic clk_in = 1'b0;
  logic rst_n = 1'b0, arm = 1'b0, abort = 1'b0, trigger = 1'b0;
  logic [15:0] cfg_delay = '0, cfg_width = '0, cfg_gap = '0;
  logic [7:0] cfg_repeat = '0, cfg_mode = '0;
  logic glitch_en, armed, busy, done, cfg_err;
  logic [7:0] glitch_mode, pulse_cnt;
  int errors = 0, checks = 0;
  logic [10:0] sb[$];

  always #5 clk_in = ~clk_in;

  glitch_sequencer dut (
    .clk_in(clk_in), .rst_n(rst_n), .arm(arm), .abort(abort), .trigger(trigger),
    .cfg_delay(cfg_delay), .cfg_width(cfg_width), .cfg_gap(cfg_gap),
    .cfg_repeat(cfg_repeat), .cfg_mode(cfg_mode),
    .glitch_en(glitch_en), .glitch_mode(glitch_mode), .armed(armed), .busy(busy),
    .done(done), .cfg_err(cfg_err), .pulse_cnt(pulse_cnt)
  );

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  function automatic logic [10:0] obs();
    return {glitch_en, glitch_mode, done, busy};
  endfunction

  task automatic load_cfg(input int d, input int w, input int g, input int r, input int m);
    cfg_delay  = 16'(d);
    cfg_width  = 16'(w);
    cfg_gap    = 16'(g);
    cfg_repeat = 8'(r);
    cfg_mode   = 8'(m);
  endtask

  // expected {en, mode, done, busy} for cycles T+1 .. done+2
  task automatic push_run(input int d, input int w, input int g, input int r, input logic [7:0] m);
    int we, ge, re, st, dc;
    logic en;
    we = (w == 0) ? 1 : w;
    ge = (g == 0) ? 1 : g;
    re = (r == 0) ? 1 : r;
    st = 1 + d;
    dc = st + re * we + (re - 1) * ge;
    for (int k = 1; k <= dc + 2; k++) begin
      en = k >= st && k < dc && ((k - st) % (we + ge)) < we;
      sb.push_back({en, en ? m : 8'h00, k == dc, k < dc});
    end
  endtask

  task automatic do_arm;
    arm = 1'b1;
    tick;
    arm = 1'b0;
  endtask

  task automatic fire;
    trigger = 1'b1;
    repeat (3) tick;
  endtask

  task automatic test_reset;
    logic hit;
    #1;
    checks++;
    if ({glitch_en, glitch_mode, armed, busy, done, cfg_err, pulse_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=0", {glitch_en, glitch_mode, armed, busy, done, cfg_err, pulse_cnt});
    end
    repeat (3) tick;
    rst_n = 1'b1;
    tick;
    trigger = 1'b1;
    repeat (3) tick;
    trigger = 1'b0;
    hit = 1'b0;
    repeat (10) begin
      tick;
      hit |= glitch_en | busy | armed;
    end
    checks++;
    if (hit !== 1'b0) begin
      errors++;
      $display("FAIL idle_trigger activity got=%b exp=0", hit);
    end
  endtask

  task automatic test_basic;
    logic [10:0] e;
    int k;
    load_cfg(5, 3, 2, 3, 1 << MODE_INV);
    do_arm;
    checks++;
    if ({armed, busy} !== 2'b10) begin
      errors++;
      $display("FAIL basic_armed got=%b exp=10", {armed, busy});
    end
    load_cfg(1, 7, 7, 9, 8'hFF);
    tick;
    push_run(5, 3, 2, 3, 8'h04);
    fire;
    k = 0;
    while (sb.size() > 0) begin
      tick;
      k++;
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL basic k=%0d got=%h exp=%h", k, obs(), e);
      end
      if (k == 1) trigger = 1'b0;
    end
    checks++;
    if (pulse_cnt !== 8'd3) begin
      errors++;
      $display("FAIL basic_pulse_cnt got=%0d exp=3", pulse_cnt);
    end
  endtask

  task automatic test_zero_subst;
    logic [10:0] e;
    int k;
    load_cfg(0, 0, 0, 0, 1 << MODE_ONE);
    do_arm;
    push_run(0, 0, 0, 0, 8'h02);
    fire;
    k = 0;
    while (sb.size() > 0) begin
      tick;
      k++;
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL zero k=%0d got=%h exp=%h", k, obs(), e);
      end
      if (k == 1) trigger = 1'b0;
    end
    checks++;
    if (pulse_cnt !== 8'd1) begin
      errors++;
      $display("FAIL zero_pulse_cnt got=%0d exp=1", pulse_cnt);
    end
  endtask

  task automatic test_cfg_reject;
    load_cfg(3, 1, 1, 1, 0);
    do_arm;
    checks++;
    if ({cfg_err, armed} !== 2'b10) begin
      errors++;
      $display("FAIL reject_pulse got=%b exp=10", {cfg_err, armed});
    end
    tick;
    checks++;
    if ({cfg_err, armed} !== 2'b00) begin
      errors++;
      $display("FAIL reject_one_cycle got=%b exp=00", {cfg_err, armed});
    end
  endtask

  task automatic test_lockout;
    logic [10:0] e;
    int k;
    load_cfg(3, 2, 3, 2, 1 << MODE_GLA);
    do_arm;
    load_cfg(0, 5, 5, 5, 0);
    push_run(3, 2, 3, 2, 8'h08);
    fire;
    k = 0;
    while (sb.size() > 0) begin
      tick;
      k++;
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL lockout k=%0d got=%h exp=%h", k, obs(), e);
      end
      if (k == 3) begin
        checks++;
        if (cfg_err !== 1'b0) begin
          errors++;
          $display("FAIL busy_arm_cfg_err got=%b exp=0", cfg_err);
        end
      end
      case (k)
        1: trigger = 1'b0;
        2: begin trigger = 1'b1; arm = 1'b1; end
        3: arm = 1'b0;
        4: trigger = 1'b0;
        6: begin trigger = 1'b1; cfg_mode = 8'h1F; arm = 1'b1; end
        7: begin trigger = 1'b0; arm = 1'b0; end
        default: ;
      endcase
    end
    checks++;
    if ({armed, pulse_cnt} !== {1'b0, 8'd2}) begin
      errors++;
      $display("FAIL lockout_end got=%h exp=%h", {armed, pulse_cnt}, {1'b0, 8'd2});
    end
  endtask

  task automatic test_abort;
    logic [10:0] e;
    logic hit;
    int k;
    load_cfg(0, 10, 2, 4, 1 << MODE_GLB);
    do_arm;
    push_run(0, 10, 2, 4, 8'h10);
    fire;
    k = 0;
    while (k < 15) begin
      tick;
      k++;
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL abort_run k=%0d got=%h exp=%h", k, obs(), e);
      end
      if (k == 1) trigger = 1'b0;
    end
    sb.delete();
    abort = 1'b1;
    tick;
    abort = 1'b0;
    checks++;
    if ({obs(), armed, pulse_cnt} !== {11'h0, 1'b0, 8'd1}) begin
      errors++;
      $display("FAIL abort_next got=%h exp=%h", {obs(), armed, pulse_cnt}, {11'h0, 1'b0, 8'd1});
    end
    hit = 1'b0;
    repeat (25) begin
      tick;
      hit |= done | glitch_en | busy;
    end
    checks++;
    if (hit !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_done got=%b exp=0", hit);
    end
    load_cfg(1, 1, 1, 1, 8'h02);
    arm = 1'b1;
    abort = 1'b1;
    tick;
    arm = 1'b0;
    abort = 1'b0;
    checks++;
    if ({armed, cfg_err, pulse_cnt} !== {2'b00, 8'd1}) begin
      errors++;
      $display("FAIL abort_over_arm got=%h exp=%h", {armed, cfg_err, pulse_cnt}, {2'b00, 8'd1});
    end
  endtask

  task automatic test_trig_hold;
    logic hit;
    trigger = 1'b1;
    repeat (4) tick;
    load_cfg(2, 1, 1, 1, 8'h02);
    do_arm;
    hit = 1'b0;
    repeat (10) begin
      tick;
      hit |= busy | glitch_en;
    end
    checks++;
    if ({hit, armed} !== 2'b01) begin
      errors++;
      $display("FAIL held_trigger got=%b exp=01", {hit, armed});
    end
    trigger = 1'b0;
    repeat (3) tick;
    #3 trigger = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick;
      checks++;
      if ({armed, busy} !== ((i < 4) ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL trig_latency i=%0d got=%b exp=%b", i, {armed, busy}, (i < 4) ? 2'b10 : 2'b01);
      end
    end
    repeat (8) tick;
    trigger = 1'b0;
    tick;
  endtask

  task automatic test_async_reset;
    logic hit;
    int n;
    load_cfg(2, 3, 2, 2, 1 << MODE_GLA);
    do_arm;
    fire;
    trigger = 1'b0;
    n = 0;
    while (glitch_en !== 1'b1 && n < 20) begin
      tick;
      n++;
    end
    checks++;
    if (glitch_en !== 1'b1) begin
      errors++;
      $display("FAIL async_wait_pulse timeout got=%b exp=1", glitch_en);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({glitch_en, glitch_mode, armed, busy, done, cfg_err, pulse_cnt} !== '0) begin
      errors++;
      $display("FAIL async_reset got=%h exp=0", {glitch_en, glitch_mode, armed, busy, done, cfg_err, pulse_cnt});
    end
    tick;
    rst_n = 1'b1;
    tick;
    trigger = 1'b1;
    repeat (2) tick;
    trigger = 1'b0;
    hit = 1'b0;
    repeat (10) begin
      tick;
      hit |= glitch_en | armed | busy;
    end
    checks++;
    if (hit !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_trigger got=%b exp=0", hit);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_basic;
    test_zero_subst;
    test_cfg_reject;
    test_lockout;
    test_abort;
    test_trig_hold;
    test_async_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
